// File: rtl/sobel_pipe_core.sv
// Three-stage pipelined Sobel edge core: gradients, magnitude, then threshold/mode/output.
// A single global advance signal moves or freezes every stage together under backpressure.
module sobel_pipe_core #(
   parameter int PIX_W = 8,
   parameter int CNT_W = 24
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [9*PIX_W-1:0] win_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [1:0]         mode_i,
   input  logic [PIX_W+2:0]   thresh_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [PIX_W-1:0]   pixel_o,
   output logic               edge_o,
   input  logic               clr_i,
   output logic [CNT_W-1:0]   edge_cnt_o
);

   localparam int GW = PIX_W + 3;
   localparam logic [GW-1:0] PIX_MAX = {{3{1'b0}}, {PIX_W{1'b1}}};

   function automatic logic [GW-1:0] px(input logic [9*PIX_W-1:0] w, input int r, input int c);
      return {{3{1'b0}}, w[(3*r+c)*PIX_W +: PIX_W]};
   endfunction

   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [GW-1:0]    gx_q, gx_d, gy_q, gy_d;
   logic [1:0]       mode1_q, mode1_d, mode2_q, mode2_d;
   logic [GW-1:0]    thr1_q, thr1_d, thr2_q, thr2_d;
   logic [GW-1:0]    mag_q, mag_d;
   logic [PIX_W-1:0] pixel_q, pixel_d;
   logic             edge_q, edge_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic          advance;
   logic [GW-1:0] sum_r, sum_l, sum_t, sum_b;
   logic [GW-1:0] abs_gx, abs_gy;
   logic          edge_new;

   assign advance = !v3_q || out_ready_i;

   always_comb begin
      sum_r = px(win_i, 0, 2) + (px(win_i, 1, 2) << 1) + px(win_i, 2, 2);
      sum_l = px(win_i, 0, 0) + (px(win_i, 1, 0) << 1) + px(win_i, 2, 0);
      sum_t = px(win_i, 0, 0) + (px(win_i, 0, 1) << 1) + px(win_i, 0, 2);
      sum_b = px(win_i, 2, 0) + (px(win_i, 2, 1) << 1) + px(win_i, 2, 2);
      // Two's-complement differences; GW bits hold +/-4*(2^PIX_W-1) without overflow.
      abs_gx   = gx_q[GW-1] ? (~gx_q + 1'b1) : gx_q;
      abs_gy   = gy_q[GW-1] ? (~gy_q + 1'b1) : gy_q;
      edge_new = (mag_q > thr2_q);

      v1_d    = v1_q;
      gx_d    = gx_q;
      gy_d    = gy_q;
      mode1_d = mode1_q;
      thr1_d  = thr1_q;
      v2_d    = v2_q;
      mag_d   = mag_q;
      mode2_d = mode2_q;
      thr2_d  = thr2_q;
      v3_d    = v3_q;
      pixel_d = pixel_q;
      edge_d  = edge_q;

      if (advance) begin
         v1_d = in_valid_i;
         if (in_valid_i) begin
            gx_d    = sum_r - sum_l;
            gy_d    = sum_t - sum_b;
            mode1_d = mode_i;
            thr1_d  = thresh_i;
         end
         v2_d = v1_q;
         if (v1_q) begin
            mag_d   = abs_gx + abs_gy;
            mode2_d = mode1_q;
            thr2_d  = thr1_q;
         end
         v3_d = v2_q;
         if (v2_q) begin
            edge_d = edge_new;
            unique case (mode2_q)
               2'b00:   pixel_d = {PIX_W{edge_new}};
               2'b01:   pixel_d = (mag_q > PIX_MAX) ? {PIX_W{1'b1}} : mag_q[PIX_W-1:0];
               2'b10:   pixel_d = mag_q[GW-1:3];
               default: pixel_d = '0;
            endcase
         end
      end

      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (v3_q && out_ready_i && edge_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         gx_q    <= '0;
         gy_q    <= '0;
         mode1_q <= '0;
         thr1_q  <= '0;
         mag_q   <= '0;
         mode2_q <= '0;
         thr2_q  <= '0;
         pixel_q <= '0;
         edge_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         mode1_q <= mode1_d;
         thr1_q  <= thr1_d;
         mag_q   <= mag_d;
         mode2_q <= mode2_d;
         thr2_q  <= thr2_d;
         pixel_q <= pixel_d;
         edge_q  <= edge_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready_o  = advance;
   assign out_valid_o = v3_q;
   assign pixel_o     = pixel_q;
   assign edge_o      = edge_q;
   assign edge_cnt_o  = cnt_q;

endmodule

// File: tb/tb_sobel_pipe_core.sv
// Directed bench for sobel_pipe_core: latency, thresholds, modes, backpressure, counter, reset.
// Note: Sobel magnitudes are always even, so the threshold boundary is exercised at G=254/256.
module tb_sobel_pipe_core;
   localparam int PIX_W = 8;
   localparam int CNT_W = 4;
   localparam int GW    = PIX_W + 3;

   logic               clk_i = 1'b0;
   logic               rst_n_i = 1'b0;
   logic [9*PIX_W-1:0] win_i = '0;
   logic               in_valid_i = 1'b0;
   logic               in_ready_o;
   logic [1:0]         mode_i = 2'b00;
   logic [GW-1:0]      thresh_i = '0;
   logic               out_valid_o;
   logic               out_ready_i = 1'b1;
   logic [PIX_W-1:0]   pixel_o;
   logic               edge_o;
   logic               clr_i = 1'b0;
   logic [CNT_W-1:0]   edge_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   sobel_pipe_core #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .win_i(win_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .mode_i(mode_i), .thresh_i(thresh_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pixel_o(pixel_o),
      .edge_o(edge_o), .clr_i(clr_i), .edge_cnt_o(edge_cnt_o)
   );

   function automatic logic [9*PIX_W-1:0] mk_win(input int p00, input int p01, input int p02,
                                                 input int p10, input int p11, input int p12,
                                                 input int p20, input int p21, input int p22);
      logic [9*PIX_W-1:0] w;
      int v[9];
      v = '{p00, p01, p02, p10, p11, p12, p20, p21, p22};
      for (int i = 0; i < 9; i++) w[i*PIX_W +: PIX_W] = PIX_W'(v[i]);
      return w;
   endfunction

   function automatic logic [9*PIX_W-1:0] win_sel(input int sel);
      case (sel)
         0:       return mk_win(0, 0, 255, 0, 0, 255, 0, 0, 255); // G = 1020
         1:       return mk_win(100, 100, 100, 100, 100, 100, 100, 100, 100); // G = 0
         2:       return mk_win(0, 0, 0, 0, 0, 127, 0, 0, 0); // G = 254
         default: return mk_win(0, 0, 0, 0, 0, 128, 0, 0, 0); // G = 256
      endcase
   endfunction

   task automatic send_win(input logic [9*PIX_W-1:0] w, input logic [1:0] m, input logic [GW-1:0] t);
      bit ok;
      ok = 1'b0;
      @(negedge clk_i);
      win_i = w; mode_i = m; thresh_i = t; in_valid_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (in_ready_o) begin ok = 1'b1; break; end
         @(negedge clk_i);
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: in_ready_o stayed 0, required 1");
      end
      @(posedge clk_i);
      #1 in_valid_i = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid_o && lat < 10) begin
         @(posedge clk_i);
         #1 lat++;
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({out_valid_o, pixel_o, edge_o, edge_cnt_o, in_ready_o} !== {1'b0, 8'd0, 1'b0, 4'd0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: valid=%0b pix=%0d edge=%0b cnt=%0d rdy=%0b required 0 0 0 0 1",
                  out_valid_o, pixel_o, edge_o, edge_cnt_o, in_ready_o);
      end
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      n_cmp++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: rdy=%0b valid=%0b required 1 0", in_ready_o, out_valid_o);
      end
   endtask

   task automatic test_basic();
      int lat;
      send_win(win_sel(0), 2'b00, 11'd255);
      wait_out(lat);
      n_cmp++;
      if (lat != 3 || out_valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL basic_latency: got %0d valid=%0b required 3 valid=1", lat, out_valid_o);
      end
      n_cmp++;
      if (pixel_o !== 8'd255 || edge_o !== 1'b1) begin
         n_err++;
         $display("FAIL basic_value: pix=%0d edge=%0b required 255 1", pixel_o, edge_o);
      end
      @(posedge clk_i); #1;
      n_cmp++;
      if (edge_cnt_o !== 4'd1 || out_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL basic_count: cnt=%0d valid=%0b required 1 0", edge_cnt_o, out_valid_o);
      end
   endtask

   task automatic test_threshold();
      int sel[3]  = '{2, 2, 3};
      int thr[3]  = '{254, 253, 255};
      int epix[3] = '{0, 255, 255};
      int eedg[3] = '{0, 1, 1};
      int lat;
      for (int i = 0; i < 3; i++) begin
         send_win(win_sel(sel[i]), 2'b00, GW'(thr[i]));
         wait_out(lat);
         n_cmp++;
         if (out_valid_o !== 1'b1 || pixel_o !== PIX_W'(epix[i]) || edge_o !== 1'(eedg[i])) begin
            n_err++;
            $display("FAIL threshold_%0d: valid=%0b pix=%0d edge=%0b required 1 %0d %0d",
                     i, out_valid_o, pixel_o, edge_o, epix[i], eedg[i]);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_modes();
      int sel[10]  = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
      int mode[10] = '{1, 2, 3, 0, 1, 2, 3, 1, 2, 3};
      int thr[10]  = '{255, 255, 255, 0, 0, 0, 0, 0, 0, 0};
      int epix[10] = '{255, 127, 0, 0, 0, 0, 0, 254, 31, 0};
      int eedg[10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
      int lat;
      for (int i = 0; i < 10; i++) begin
         send_win(win_sel(sel[i]), 2'(mode[i]), GW'(thr[i]));
         wait_out(lat);
         n_cmp++;
         if (out_valid_o !== 1'b1 || pixel_o !== PIX_W'(epix[i]) || edge_o !== 1'(eedg[i])) begin
            n_err++;
            $display("FAIL mode_%0d: valid=%0b pix=%0d edge=%0b required 1 %0d %0d",
                     i, out_valid_o, pixel_o, edge_o, epix[i], eedg[i]);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_backpressure();
      int src, rcv, c;
      bit pxf, stall_prev, idle_ok;
      logic [PIX_W-1:0] hold_pix;
      logic hold_edge;
      src = 0; rcv = 0; pxf = 1'b0; stall_prev = 1'b0; hold_pix = '0; hold_edge = 1'b0;
      for (c = 0; c < 60 && rcv < 10; c++) begin
         @(negedge clk_i);
         if (pxf) src++;
         in_valid_i  = (src < 10);
         win_i       = mk_win(0, 0, 0, 0, 0, 10*(src+1), 0, 0, 0);
         mode_i      = 2'b01;
         thresh_i    = 11'd100;
         out_ready_i = !(c >= 4 && c <= 7);
         #1;
         n_cmp++;
         if (in_ready_o !== (!out_valid_o || out_ready_i)) begin
            n_err++;
            $display("FAIL bp_ready_c%0d: rdy=%0b required %0b", c, in_ready_o, !out_valid_o || out_ready_i);
         end
         if (c >= 5 && c <= 7) begin
            n_cmp++;
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
               n_err++;
               $display("FAIL bp_stall_c%0d: rdy=%0b valid=%0b required 0 1", c, in_ready_o, out_valid_o);
            end
         end
         if (stall_prev) begin
            n_cmp++;
            if (out_valid_o !== 1'b1 || pixel_o !== hold_pix || edge_o !== hold_edge) begin
               n_err++;
               $display("FAIL bp_hold_c%0d: valid=%0b pix=%0d edge=%0b required 1 %0d %0b",
                        c, out_valid_o, pixel_o, edge_o, hold_pix, hold_edge);
            end
         end
         if (out_valid_o && out_ready_i) begin
            n_cmp++;
            if (pixel_o !== PIX_W'(20*(rcv+1)) || edge_o !== (rcv >= 5)) begin
               n_err++;
               $display("FAIL bp_data_%0d: pix=%0d edge=%0b required %0d %0b",
                        rcv, pixel_o, edge_o, 20*(rcv+1), rcv >= 5);
            end
            rcv++;
         end
         stall_prev = out_valid_o && !out_ready_i;
         hold_pix   = pixel_o;
         hold_edge  = edge_o;
         pxf        = in_valid_i && in_ready_o;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      n_cmp++;
      if (rcv != 10) begin
         n_err++;
         $display("FAIL bp_count: got %0d outputs required 10", rcv);
      end
      idle_ok = 1'b1;
      repeat (4) begin
         @(posedge clk_i); #1;
         if (out_valid_o) idle_ok = 1'b0;
      end
      n_cmp++;
      if (!idle_ok) begin
         n_err++;
         $display("FAIL bp_no_dup: extra output seen, required none");
      end
   endtask

   task automatic test_counter();
      int lat;
      @(negedge clk_i); clr_i = 1'b1;
      @(negedge clk_i); clr_i = 1'b0;
      n_cmp++;
      if (edge_cnt_o !== 4'd0) begin
         n_err++;
         $display("FAIL cnt_clear: got %0d required 0", edge_cnt_o);
      end
      for (int burst = 0; burst < 2; burst++) begin
         @(negedge clk_i);
         win_i = win_sel(0); mode_i = 2'b00; thresh_i = '0; in_valid_i = 1'b1;
         repeat (10) @(posedge clk_i);
         #1 in_valid_i = 1'b0;
         repeat (5) @(posedge clk_i);
         #1;
         n_cmp++;
         if (edge_cnt_o !== ((burst == 0) ? 4'd10 : 4'd15)) begin
            n_err++;
            $display("FAIL cnt_burst_%0d: got %0d required %0d", burst, edge_cnt_o, (burst == 0) ? 10 : 15);
         end
      end
      send_win(win_sel(0), 2'b00, '0);
      wait_out(lat);
      clr_i = 1'b1;
      @(posedge clk_i);
      #1 clr_i = 1'b0;
      n_cmp++;
      if (edge_cnt_o !== 4'd0) begin
         n_err++;
         $display("FAIL cnt_clr_collide: got %0d required 0", edge_cnt_o);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit idle_ok;
      @(negedge clk_i);
      win_i = win_sel(0); mode_i = 2'b01; thresh_i = '0; in_valid_i = 1'b1; out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      rst_n_i = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid_o, pixel_o, edge_o, edge_cnt_o, in_ready_o} !== {1'b0, 8'd0, 1'b0, 4'd0, 1'b1}) begin
         n_err++;
         $display("FAIL midrst_state: valid=%0b pix=%0d edge=%0b cnt=%0d rdy=%0b required 0 0 0 0 1",
                  out_valid_o, pixel_o, edge_o, edge_cnt_o, in_ready_o);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      idle_ok = 1'b1;
      repeat (5) begin
         @(posedge clk_i); #1;
         if (out_valid_o) idle_ok = 1'b0;
      end
      n_cmp++;
      if (!idle_ok) begin
         n_err++;
         $display("FAIL midrst_stale: stale output after reset, required none");
      end
      send_win(win_sel(2), 2'b01, '0);
      wait_out(lat);
      n_cmp++;
      if (lat != 3 || out_valid_o !== 1'b1 || pixel_o !== 8'd254 || edge_o !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_new: lat=%0d valid=%0b pix=%0d edge=%0b required 3 1 254 1",
                  lat, out_valid_o, pixel_o, edge_o);
      end
      @(posedge clk_i); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_threshold();
      test_modes();
      test_backpressure();
      test_counter();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
